// File: rtl/tff_bank_sequencer_if.sv
// tff_bank_sequencer_if: command valid/ready channel into the T_FF bank sequencer
interface tff_bank_sequencer_if #(parameter int WIDTH = 4, parameter int STEP_W = 8);
  logic              Cmd_Valid;
  logic              Cmd_Ready;
  logic [1:0]        Cmd_Op;
  logic [WIDTH-1:0]  Cmd_Data;
  logic [STEP_W-1:0] Cmd_Steps;
  modport master (output Cmd_Valid, Cmd_Op, Cmd_Data, Cmd_Steps, input Cmd_Ready);
  modport slave  (input Cmd_Valid, Cmd_Op, Cmd_Data, Cmd_Steps, output Cmd_Ready);
endinterface

// File: rtl/tff_bank_sequencer.sv
// tff_bank_sequencer: drives the T inputs of a T_FF bank to count up/down N steps or load a value
module tff_bank_sequencer #(
  parameter int WIDTH  = 4,
  parameter int STEP_W = 8
) (
  input  logic                 Clk,
  input  logic                 Reset,
  tff_bank_sequencer_if.slave  cmd,
  input  logic                 Abort,
  input  logic [WIDTH-1:0]     Q_In,
  output logic [WIDTH-1:0]     T_Out,
  output logic                 Busy,
  output logic                 Done,
  output logic                 Aborted,
  output logic [STEP_W-1:0]    Steps_Left
);
  typedef enum logic [1:0] {IDLE, COUNT, LOAD, DONE} state_t;
  state_t            state_q, state_d;
  logic              dir_q, dir_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [STEP_W-1:0] steps_q, steps_d;
  logic              aborted_q, aborted_d;
  logic [WIDTH-1:0]  up_t, dn_t;
  // ripple toggle enables: a bit flips when every lower bit is 1 (up) or 0 (down)
  assign up_t[0] = 1'b1;
  assign dn_t[0] = 1'b1;
  for (genvar i = 1; i < WIDTH; i++) begin : g_chain
    assign up_t[i] = up_t[i-1] & Q_In[i-1];
    assign dn_t[i] = dn_t[i-1] & ~Q_In[i-1];
  end
  assign T_Out = (state_q == COUNT && !Abort) ? (dir_q ? dn_t : up_t) :
                 (state_q == LOAD) ? (Q_In ^ data_q) : '0;
  assign cmd.Cmd_Ready = state_q == IDLE;
  assign Busy          = state_q == COUNT || state_q == LOAD;
  assign Done          = state_q == DONE;
  assign Aborted       = Done && aborted_q;
  assign Steps_Left    = steps_q;
  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    data_d    = data_q;
    steps_d   = steps_q;
    aborted_d = aborted_q;
    case (state_q)
      IDLE: if (cmd.Cmd_Valid) begin
        dir_d     = cmd.Cmd_Op[1];
        data_d    = cmd.Cmd_Data;
        aborted_d = 1'b0;
        state_d   = (cmd.Cmd_Op == 2'b11) ? LOAD :
                    (cmd.Cmd_Op == 2'b00 || cmd.Cmd_Steps == '0) ? DONE : COUNT;
        steps_d   = (state_d == COUNT) ? cmd.Cmd_Steps : '0;
      end
      COUNT: if (Abort) begin
        state_d   = DONE;
        aborted_d = 1'b1;
      end else begin
        steps_d = steps_q - 1'b1;
        state_d = (steps_q == 1) ? DONE : COUNT;
      end
      LOAD: state_d = DONE;
      DONE: begin
        state_d   = IDLE;
        aborted_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      dir_q     <= 1'b0;
      data_q    <= '0;
      steps_q   <= '0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      data_q    <= data_d;
      steps_q   <= steps_d;
      aborted_q <= aborted_d;
    end
  end
endmodule
